// File: rtl/bitstrip_packer.sv
// bitstrip_packer: strips each delta chunk down to its low n bits, packs the
// resulting payloads MSB-first into an accumulator and emits fixed-width flits.
// A word flagged in_last flushes the remaining bits as a final, zero-padded flit.
module bitstrip_packer #(
  parameter int INPUT_WIDTH  = 128,
  parameter int OUTPUT_WIDTH = 128,
  parameter int CHUNK_SIZE   = 8,
  parameter int EN_BITS      = 4
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [INPUT_WIDTH-1:0]              deltas_in,
  input  logic [EN_BITS-1:0]                  en_bits,
  input  logic                                in_last,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [OUTPUT_WIDTH-1:0]             out_data,
  output logic [$clog2(OUTPUT_WIDTH+1)-1:0]   out_bits,
  output logic                                out_last,
  output logic                                err
);

  localparam int NUM_CHUNKS = INPUT_WIDTH / CHUNK_SIZE;
  localparam int ACC_W      = OUTPUT_WIDTH + INPUT_WIDTH;
  localparam int FW         = $clog2(ACC_W + 1);
  localparam int OBW        = $clog2(OUTPUT_WIDTH + 1);

  // state | meaning
  // ACCUM | collecting payload bits; a flit is offered once fill reaches OUTPUT_WIDTH
  // FLUSH | packet ended; drain every remaining bit, last flit zero-padded
  typedef enum logic {ACCUM, FLUSH} state_t;

  state_t            state_q;
  logic [ACC_W-1:0]  acc_q;
  logic [FW-1:0]     fill_q;
  logic              err_q;

  logic                    n_legal_d;
  logic [FW-1:0]           len_d;
  logic [CHUNK_SIZE-1:0]   chunk_d;
  logic [INPUT_WIDTH-1:0]  payload_d;
  logic [ACC_W-1:0]        append_d;
  logic [OUTPUT_WIDTH-1:0] keep_mask_d;
  logic                    flit_valid_d;
  logic                    full_d;

  // Legality of n and payload length L = NUM_CHUNKS * n.
  always_comb begin
    n_legal_d = (en_bits != '0) && (en_bits <= EN_BITS'(CHUNK_SIZE));
    len_d     = FW'(NUM_CHUNKS) * FW'(en_bits);
  end

  // Strip every chunk to its low n bits and concatenate, top chunk first.
  always_comb begin
    payload_d = '0;
    chunk_d   = '0;
    for (int k = NUM_CHUNKS - 1; k >= 0; k--) begin
      chunk_d   = deltas_in[k*CHUNK_SIZE +: CHUNK_SIZE] &
                  ~({CHUNK_SIZE{1'b1}} << en_bits);
      payload_d = (payload_d << en_bits) | INPUT_WIDTH'(chunk_d);
    end
  end

  // Left-align the payload, then slide it down just below the bits already held.
  // Bits of acc_q below fill are always zero, so an OR is enough to append.
  always_comb begin
    append_d = (ACC_W'(payload_d) << (FW'(ACC_W) - len_d)) >> fill_q;
  end

  // Output decode; everything here is a function of registered state only.
  always_comb begin
    full_d       = (fill_q >= FW'(OUTPUT_WIDTH));
    flit_valid_d = (state_q == FLUSH) || full_d;
    keep_mask_d  = ~({OUTPUT_WIDTH{1'b1}} >> fill_q);
  end

  assign in_ready  = !rst && (state_q == ACCUM) && !full_d;
  assign out_valid = flit_valid_d;
  assign out_data  = flit_valid_d ? (acc_q[ACC_W-1 -: OUTPUT_WIDTH] & keep_mask_d) : '0;
  assign out_last  = (state_q == FLUSH) && (fill_q <= FW'(OUTPUT_WIDTH));
  assign err       = err_q;

  // Flit bit count: full width except for the final partial flit of a flush.
  always_comb begin
    out_bits = '0;
    if (flit_valid_d) begin
      if ((state_q == FLUSH) && !full_d) out_bits = fill_q[OBW-1:0];
      else                               out_bits = OBW'(OUTPUT_WIDTH);
    end
  end

  // Accumulator, fill counter, packet state and error pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ACCUM;
      acc_q   <= '0;
      fill_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        ACCUM: begin
          if (flit_valid_d && out_ready) begin
            acc_q  <= acc_q << OUTPUT_WIDTH;
            fill_q <= fill_q - FW'(OUTPUT_WIDTH);
          end else if (in_valid && in_ready) begin
            if (n_legal_d) begin
              acc_q  <= acc_q | append_d;
              fill_q <= fill_q + len_d;
            end else begin
              err_q <= 1'b1;
            end
            if (in_last) state_q <= FLUSH;
          end
        end
        FLUSH: begin
          if (out_ready) begin
            if (fill_q > FW'(OUTPUT_WIDTH)) begin
              acc_q  <= acc_q << OUTPUT_WIDTH;
              fill_q <= fill_q - FW'(OUTPUT_WIDTH);
            end else begin
              acc_q   <= '0;
              fill_q  <= '0;
              state_q <= ACCUM;
            end
          end
        end
        default: state_q <= ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_bitstrip_packer.sv
// Scoreboard bench for bitstrip_packer: a bit-queue model turns every accepted
// word into expected flits; an independent monitor checks flits as they leave.
module tb_bitstrip_packer;
  localparam int IW = 128;
  localparam int OW = 128;
  localparam int CS = 8;
  localparam int EB = 4;
  localparam int NC = IW / CS;

  typedef struct {
    logic [OW-1:0] data;
    int            bits;
    bit            last;
  } flit_t;

  logic                      clk = 1'b0;
  logic                      rst = 1'b1;
  logic                      in_valid = 1'b0;
  logic                      in_ready;
  logic [IW-1:0]             deltas_in = '0;
  logic [EB-1:0]             en_bits = '0;
  logic                      in_last = 1'b0;
  logic                      out_valid;
  logic                      out_ready = 1'b0;
  logic [OW-1:0]             out_data;
  logic [$clog2(OW+1)-1:0]   out_bits;
  logic                      out_last;
  logic                      err;

  flit_t exp_q[$];
  bit    bq[$];
  int    vectors = 0;
  int    miscompares = 0;
  int    exp_err = 0;
  int    obs_err = 0;
  bit    stall = 1'b0;

  bitstrip_packer #(.INPUT_WIDTH(IW), .OUTPUT_WIDTH(OW), .CHUNK_SIZE(CS), .EN_BITS(EB)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .deltas_in(deltas_in), .en_bits(en_bits), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_bits(out_bits), .out_last(out_last), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(string nm, logic [OW-1:0] act, logic [OW-1:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", nm, act, expv);
    end
  endtask

  // Pop nb bits off the stream into one MSB-aligned, zero-padded flit.
  function automatic void emit(int nb, bit last);
    flit_t f;
    f.data = '0;
    for (int i = 0; i < nb; i++) f.data[OW-1-i] = bq.pop_front();
    f.bits = nb;
    f.last = last;
    exp_q.push_back(f);
  endfunction

  // Reference: bit stream built chunk by chunk, flits cut off as the rules say.
  function automatic void model_word(logic [IW-1:0] d, int n, bit last);
    if (n >= 1 && n <= CS) begin
      for (int k = NC - 1; k >= 0; k--)
        for (int b = n - 1; b >= 0; b--)
          bq.push_back(d[k*CS+b]);
    end else begin
      exp_err++;
    end
    if (!last) begin
      while (bq.size() >= OW) emit(OW, 1'b0);
    end else begin
      while (bq.size() > OW) emit(OW, 1'b0);
      emit(bq.size(), 1'b1);
    end
  endfunction

  task automatic send(logic [IW-1:0] d, int n, bit last);
    int budget;
    budget = 0;
    @(negedge clk);
    in_valid  = 1'b1;
    deltas_in = d;
    en_bits   = n[EB-1:0];
    in_last   = last;
    while (!in_ready && budget < 500) begin
      @(negedge clk);
      budget++;
    end
    vectors++;
    if (!in_ready) begin
      miscompares++;
      $display("FAIL in_ready_timeout: got in_ready=%0b expected 1 within 500 cycles", in_ready);
    end else begin
      model_word(d, n, last);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic wait_drain();
    int budget;
    budget = 0;
    while ((exp_q.size() != 0 || out_valid) && budget < 3000) begin
      @(negedge clk);
      budget++;
    end
    vectors++;
    if (exp_q.size() != 0 || out_valid) begin
      miscompares++;
      $display("FAIL drain_timeout: got %0d flits outstanding, out_valid=%0b expected 0", exp_q.size(), out_valid);
    end
  endtask

  // Monitor: drives out_ready, checks each consumed flit and stall stability.
  logic [OW-1:0] hold_data;
  logic [OW-1:0] hold_bits;
  bit            hold_last;
  bit            have_hold = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      have_hold = 1'b0;
    end else begin
      out_ready = stall ? 1'b0 : ($urandom_range(0, 3) != 0);
      if (have_hold && out_valid) begin
        chk("stall_data", out_data, hold_data);
        chk("stall_bits", OW'(out_bits), hold_bits);
        chk("stall_last", OW'(out_last), OW'(hold_last));
      end
      have_hold = 1'b0;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_flit: got data %h bits %0d, expected no flit", out_data, out_bits);
        end else begin
          flit_t f;
          f = exp_q.pop_front();
          chk("flit_data", out_data, f.data);
          chk("flit_bits", OW'(out_bits), OW'(f.bits));
          chk("flit_last", OW'(out_last), OW'(f.last));
        end
      end else if (out_valid) begin
        hold_data = out_data;
        hold_bits = OW'(out_bits);
        hold_last = out_last;
        have_hold = 1'b1;
      end
      if (err) obs_err++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [IW-1:0] w;
    // Reset state
    #12;
    chk("rst_out_valid", OW'(out_valid), '0);
    chk("rst_in_ready", OW'(in_ready), '0);
    chk("rst_out_data", out_data, '0);
    chk("rst_out_bits", OW'(out_bits), '0);
    chk("rst_out_last", OW'(out_last), '0);
    chk("rst_err", OW'(err), '0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", OW'(in_ready), OW'(1));

    // Two n=4 words of 0x0F chunks -> one all-ones flit, not last
    send({16{8'h0F}}, 4, 1'b0);
    send({16{8'h0F}}, 4, 1'b0);
    wait_drain();

    // n=8 single word with last -> flit equals input
    send(128'h0123456789ABCDEF0123456789ABCDEF, 8, 1'b1);
    wait_drain();

    // n=3, chunks 0x05 -> 48-bit final flit
    send({16{8'h05}}, 3, 1'b1);
    wait_drain();

    // Illegal n=0 followed by a legal last word
    send({4{$urandom}}, 0, 1'b0);
    send(128'hFEDCBA98765432100011223344556677, 8, 1'b1);
    wait_drain();

    // Empty flush: last word with illegal n and nothing buffered
    send({4{$urandom}}, 12, 1'b1);
    wait_drain();

    // Backpressure: full flit pending for 10 cycles
    stall = 1'b1;
    send({4{$urandom}}, 4, 1'b0);
    send({4{$urandom}}, 4, 1'b0);
    repeat (10) begin
      @(negedge clk);
      #1;
      chk("stall_in_ready", OW'(in_ready), '0);
      chk("stall_out_valid", OW'(out_valid), OW'(1));
    end
    stall = 1'b0;
    wait_drain();

    // Reset mid-packet discards buffered bits
    send({16{8'h0F}}, 4, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    bq.delete();
    #1;
    chk("midrst_out_valid", OW'(out_valid), '0);
    chk("midrst_in_ready", OW'(in_ready), '0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_release_in_ready", OW'(in_ready), OW'(1));
    chk("midrst_release_out_valid", OW'(out_valid), '0);
    send(128'h00112233445566778899AABBCCDDEEFF, 8, 1'b1);
    wait_drain();

    // Randomized traffic, n covering legal and illegal values
    for (int i = 0; i < 120; i++) begin
      w = {$urandom, $urandom, $urandom, $urandom};
      send(w, int'($urandom_range(0, 11)), ($urandom_range(0, 5) == 0));
    end
    send({$urandom, $urandom, $urandom, $urandom}, 8, 1'b1);
    wait_drain();

    repeat (3) @(negedge clk);
    chk("err_pulse_count", OW'(obs_err), OW'(exp_err));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bitstrip_packer.md
BITSTRIP_PACKER -- requirements
Module: bitstrip_packer

Interface
REQ-001 Parameter INPUT_WIDTH, default 128: input delta word width in bits.
REQ-002 Parameter OUTPUT_WIDTH, default 128: output flit width; SHALL be >= INPUT_WIDTH.
REQ-003 Parameter CHUNK_SIZE, default 8: width of one delta chunk; INPUT_WIDTH SHALL be a multiple of it.
REQ-004 Parameter EN_BITS, default 4: width of en_bits; SHALL be >= clog2(CHUNK_SIZE+1).
REQ-005 Derived NUM_CHUNKS = INPUT_WIDTH/CHUNK_SIZE; ACC_W = OUTPUT_WIDTH+INPUT_WIDTH.
REQ-006 clk  in  1  single clock; all state changes on rising edge.
REQ-007 rst  in  1  asynchronous, active-high reset.
REQ-008 in_valid  in  1  input word offered.
REQ-009 in_ready  out  1  block can accept an input word this cycle.
REQ-010 deltas_in  in  INPUT_WIDTH  delta chunks; chunk k occupies bits [k*CHUNK_SIZE +: CHUNK_SIZE].
REQ-011 en_bits  in  EN_BITS  kept bits per chunk (n).
REQ-012 in_last  in  1  final word of a packet; triggers flush.
REQ-013 out_valid  out  1  flit available.
REQ-014 out_ready  in  1  downstream accepts flit.
REQ-015 out_data  out  OUTPUT_WIDTH  packed flit, MSB-aligned, zero-padded.
REQ-016 out_bits  out  clog2(OUTPUT_WIDTH+1)  count of meaningful bits in out_data.
REQ-017 out_last  out  1  flit is the final flit of a packet.
REQ-018 err  out  1  one-cycle pulse: accepted word had illegal en_bits.

Function
REQ-019 Input handshake: word accepted in a cycle where in_valid && in_ready.
REQ-020 Output handshake: flit consumed in a cycle where out_valid && out_ready; out_data/out_bits/out_last SHALL hold stable while out_valid && !out_ready.
REQ-021 Legal n: 1 <= n <= CHUNK_SIZE; payload length L = NUM_CHUNKS*n.
REQ-022 Strip: each chunk keeps its low n bits; payload = concatenation, chunk NUM_CHUNKS-1 most significant, chunk 0 least significant.
REQ-023 Accumulator acc[ACC_W-1:0] with fill counter (0..ACC_W); accepted payload written MSB-first immediately below the current fill bits, fill += L.
REQ-024 State ACCUM: in_ready = (fill < OUTPUT_WIDTH); out_valid = (fill >= OUTPUT_WIDTH); out_bits = OUTPUT_WIDTH; out_last = 0.
REQ-025 In ACCUM, on flit consumption: acc shifts left by OUTPUT_WIDTH (zero fill), fill -= OUTPUT_WIDTH.
REQ-026 out_data = acc[ACC_W-1 -: OUTPUT_WIDTH], bits below fill forced to 0.
REQ-027 Accepting a word with in_last=1 moves ACCUM -> FLUSH after the append.
REQ-028 State FLUSH: in_ready = 0; out_valid = 1; out_bits = min(fill, OUTPUT_WIDTH); out_last = (fill <= OUTPUT_WIDTH).
REQ-029 In FLUSH, on consumption with fill > OUTPUT_WIDTH: shift as REQ-025, stay FLUSH; otherwise fill = 0, acc = 0, -> ACCUM.
REQ-030 FLUSH entered with fill = 0 SHALL emit one all-zero flit, out_bits = 0, out_last = 1.
REQ-031 Illegal n (0 or > CHUNK_SIZE): word accepted, nothing appended, err = 1 the following cycle; in_last still honoured.
REQ-032 Latency: word accepted at edge t -> out_valid no earlier than edge t+1 (registered outputs, no combinational in->out path).
REQ-033 in_ready SHALL NOT depend combinationally on out_ready or in_valid.

Reset
REQ-034 On rst: acc = 0, fill = 0, state = ACCUM, out_valid = 0, out_data = 0, out_bits = 0, out_last = 0, err = 0, in_ready = 0 while rst asserted, 1 on first cycle after release.
REQ-035 rst mid-packet SHALL discard all buffered bits; no partial flit emitted after release.

Verification
REQ-036 n=4, two words 0x0F..0F (all chunks 0x0F), in_last=0 -> one flit 0xFFFF...FF (128 ones), out_bits=128, out_last=0.
REQ-037 n=8, one word 0x0123...EF with in_last=1 -> single flit equal to input, out_bits=128, out_last=1.
REQ-038 n=3, one word all chunks 0x05 with in_last=1 -> flit top 48 bits = repeating 101, rest 0, out_bits=48, out_last=1.
REQ-039 n=0 word then n=8 word with in_last=1 -> err pulse once; one flit equal to second word, out_last=1.
REQ-040 out_ready held low 10 cycles with full flit pending -> out_data stable, in_ready = 0, no data loss when released.
REQ-041 rst asserted after one n=4 word (fill=64) -> out_valid=0, fill=0; subsequent n=8 word with in_last=1 emits only that word.
